// File: rtl/enemy_bank.sv
// Shared-datapath motion engine for NUM_ENEMIES bouncing square enemies.
// Each rate tick moves one slot per cycle, then tests one slot per cycle against the player box.
module enemy_bank #(
  parameter int NUM_ENEMIES = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int RATE_DIV    = 249999,
  localparam int ID_W       = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic                       spawn_valid,
  output logic                       spawn_ready,
  input  logic [ID_W-1:0]            spawn_id,
  input  logic [X_W-1:0]             spawn_x,
  input  logic [Y_W-1:0]             spawn_y,
  input  logic [2:0]                 spawn_dx,
  input  logic [2:0]                 spawn_dy,
  input  logic                       spawn_left,
  input  logic                       spawn_up,
  input  logic [2:0]                 spawn_size,
  input  logic                       kill_valid,
  input  logic [ID_W-1:0]            kill_id,
  input  logic [X_W-1:0]             player_x,
  input  logic [Y_W-1:0]             player_y,
  input  logic [2:0]                 player_size,
  output logic [NUM_ENEMIES*X_W-1:0] enemy_x,
  output logic [NUM_ENEMIES*Y_W-1:0] enemy_y,
  output logic [NUM_ENEMIES*3-1:0]   enemy_size,
  output logic [NUM_ENEMIES-1:0]     active,
  output logic                       hit,
  output logic [ID_W-1:0]            hit_id,
  output logic                       frame_tick
);
  localparam int CNT_W = (RATE_DIV > 0) ? $clog2(RATE_DIV + 1) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_ENEMIES - 1);
  localparam logic [X_W:0]    SCR_W   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]    SCR_H   = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, UPDATE, COLLIDE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [X_W-1:0]         x_q    [NUM_ENEMIES];
  logic [X_W-1:0]         x_d    [NUM_ENEMIES];
  logic [Y_W-1:0]         y_q    [NUM_ENEMIES];
  logic [Y_W-1:0]         y_d    [NUM_ENEMIES];
  logic [2:0]             dx_q   [NUM_ENEMIES];
  logic [2:0]             dx_d   [NUM_ENEMIES];
  logic [2:0]             dy_q   [NUM_ENEMIES];
  logic [2:0]             dy_d   [NUM_ENEMIES];
  logic [2:0]             size_q [NUM_ENEMIES];
  logic [2:0]             size_d [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] left_q, left_d, up_q, up_d, active_q, active_d;
  logic                   hit_q, hit_d, frame_tick_q, frame_tick_d, ready_q, ready_d;
  logic                   acc_hit_q, acc_hit_d;
  logic [ID_W-1:0]        hit_id_q, hit_id_d, acc_id_q, acc_id_d;

  logic                   tick;
  logic [2:0]             spawn_sz;
  logic [X_W-1:0]         clamp_x, new_x;
  logic [Y_W-1:0]         clamp_y, new_y;
  logic [X_W:0]           cur_x, step_x, sz_x, px, ps_x;
  logic [Y_W:0]           cur_y, step_y, sz_y, py, ps_y;
  logic                   new_left, new_up, overlap;

  always_comb begin
    tick  = play && (cnt_q == CNT_W'(RATE_DIV));
    cnt_d = cnt_q;
    if (play) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Spawn positions are pulled back so the whole square stays on screen.
  always_comb begin
    spawn_sz = (spawn_size == 3'd0) ? 3'd1 : spawn_size;
    clamp_x  = spawn_x;
    clamp_y  = spawn_y;
    if ({1'b0, spawn_x} + (X_W+1)'(spawn_sz) > SCR_W) clamp_x = X_W'(SCR_W - (X_W+1)'(spawn_sz));
    if ({1'b0, spawn_y} + (Y_W+1)'(spawn_sz) > SCR_H) clamp_y = Y_W'(SCR_H - (Y_W+1)'(spawn_sz));
  end

  always_comb begin
    cur_x    = {1'b0, x_q[idx_q]};
    cur_y    = {1'b0, y_q[idx_q]};
    step_x   = (X_W+1)'(dx_q[idx_q]);
    step_y   = (Y_W+1)'(dy_q[idx_q]);
    sz_x     = (X_W+1)'(size_q[idx_q]);
    sz_y     = (Y_W+1)'(size_q[idx_q]);
    new_x    = x_q[idx_q];
    new_y    = y_q[idx_q];
    new_left = left_q[idx_q];
    new_up   = up_q[idx_q];
    if (dx_q[idx_q] != 3'd0) begin
      if (left_q[idx_q]) begin
        if (cur_x <= step_x) begin
          new_x    = '0;
          new_left = 1'b0;
        end else new_x = X_W'(cur_x - step_x);
      end else if (cur_x + sz_x + step_x >= SCR_W) begin
        new_x    = X_W'(SCR_W - sz_x);
        new_left = 1'b1;
      end else new_x = X_W'(cur_x + step_x);
    end
    if (dy_q[idx_q] != 3'd0) begin
      if (up_q[idx_q]) begin
        if (cur_y <= step_y) begin
          new_y  = '0;
          new_up = 1'b0;
        end else new_y = Y_W'(cur_y - step_y);
      end else if (cur_y + sz_y + step_y >= SCR_H) begin
        new_y  = Y_W'(SCR_H - sz_y);
        new_up = 1'b1;
      end else new_y = Y_W'(cur_y + step_y);
    end
    px      = {1'b0, player_x};
    py      = {1'b0, player_y};
    ps_x    = (X_W+1)'(player_size);
    ps_y    = (Y_W+1)'(player_size);
    overlap = active_q[idx_q] && (cur_x < px + ps_x) && (px < cur_x + sz_x)
                              && (cur_y < py + ps_y) && (py < cur_y + sz_y);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x_d          = x_q;
    y_d          = y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    size_d       = size_q;
    left_d       = left_q;
    up_d         = up_q;
    active_d     = active_q;
    hit_d        = hit_q;
    hit_id_d     = hit_id_q;
    acc_hit_d    = acc_hit_q;
    acc_id_d     = acc_id_q;
    frame_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Kill is applied first so a same-slot spawn overrides it.
        if (ready_q && kill_valid) active_d[kill_id] = 1'b0;
        if (ready_q && spawn_valid) begin
          x_d[spawn_id]      = clamp_x;
          y_d[spawn_id]      = clamp_y;
          dx_d[spawn_id]     = spawn_dx;
          dy_d[spawn_id]     = spawn_dy;
          left_d[spawn_id]   = spawn_left;
          up_d[spawn_id]     = spawn_up;
          size_d[spawn_id]   = spawn_sz;
          active_d[spawn_id] = 1'b1;
        end
        if (tick) begin
          state_d   = UPDATE;
          idx_d     = '0;
          acc_hit_d = 1'b0;
          acc_id_d  = '0;
        end
      end
      UPDATE: begin
        if (active_q[idx_q]) begin
          x_d[idx_q]    = new_x;
          y_d[idx_q]    = new_y;
          left_d[idx_q] = new_left;
          up_d[idx_q]   = new_up;
        end
        if (idx_q == LAST_ID) begin
          state_d = COLLIDE;
          idx_d   = '0;
        end else idx_d = idx_q + ID_W'(1);
      end
      COLLIDE: begin
        if (overlap && !acc_hit_q) begin
          acc_hit_d = 1'b1;
          acc_id_d  = idx_q;
        end
        // Results land together with frame_tick so consumers see a consistent frame.
        if (idx_q == LAST_ID) begin
          state_d      = DONE;
          frame_tick_d = 1'b1;
          hit_d        = acc_hit_d;
          hit_id_d     = acc_id_d;
        end else idx_d = idx_q + ID_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      left_q       <= '0;
      up_q         <= '0;
      active_q     <= '0;
      hit_q        <= 1'b0;
      hit_id_q     <= '0;
      acc_hit_q    <= 1'b0;
      acc_id_q     <= '0;
      frame_tick_q <= 1'b0;
      ready_q      <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        dx_q[i]   <= '0;
        dy_q[i]   <= '0;
        size_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      up_q         <= up_d;
      active_q     <= active_d;
      hit_q        <= hit_d;
      hit_id_q     <= hit_id_d;
      acc_hit_q    <= acc_hit_d;
      acc_id_q     <= acc_id_d;
      frame_tick_q <= frame_tick_d;
      ready_q      <= ready_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      size_q       <= size_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_x[i*X_W +: X_W] = x_q[i];
      enemy_y[i*Y_W +: Y_W] = y_q[i];
      enemy_size[i*3 +: 3]  = size_q[i];
    end
  end

  assign spawn_ready = ready_q;
  assign active      = active_q;
  assign hit         = hit_q;
  assign hit_id      = hit_id_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_enemy_bank.sv
// Scoreboard bench for enemy_bank: an integer reference model predicts every pass at its tick,
// and a monitor compares all outputs whenever frame_tick is presented.
module tb_enemy_bank;
  localparam int N = 4, XW = 8, YW = 7, SW = 160, SH = 120, RD = 15, PASS = 2*N+1;

  logic          clk = 1'b0;
  logic          reset, play, spawn_valid, spawn_ready, spawn_left, spawn_up, kill_valid;
  logic [1:0]    spawn_id, kill_id, hit_id;
  logic [XW-1:0] spawn_x, player_x;
  logic [YW-1:0] spawn_y, player_y;
  logic [2:0]    spawn_dx, spawn_dy, spawn_size, player_size;
  logic [N*XW-1:0] enemy_x;
  logic [N*YW-1:0] enemy_y;
  logic [N*3-1:0]  enemy_size;
  logic [N-1:0]    active;
  logic            hit, frame_tick;

  enemy_bank #(.NUM_ENEMIES(N), .X_W(XW), .Y_W(YW), .SCREEN_W(SW), .SCREEN_H(SH), .RATE_DIV(RD)) dut (
    .clk(clk), .reset(reset), .play(play),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_id(spawn_id),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .spawn_left(spawn_left), .spawn_up(spawn_up), .spawn_size(spawn_size),
    .kill_valid(kill_valid), .kill_id(kill_id),
    .player_x(player_x), .player_y(player_y), .player_size(player_size),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_size(enemy_size), .active(active),
    .hit(hit), .hit_id(hit_id), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned     edge_n;
    logic [N*XW-1:0] ex;
    logic [N*YW-1:0] ey;
    logic [N*3-1:0]  es;
    logic [N-1:0]    act;
    logic            hit;
    logic [1:0]      hid;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0, frames = 0;
  int unsigned edges = 0;
  int          mx[N], my[N], mdx[N], mdy[N], ms[N];
  bit          ml[N], mu[N], mact[N];
  int          mcnt, busy_cnt;
  bit          post_rst;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; ms[i] = 0;
      ml[i] = 0; mu[i] = 0; mact[i] = 0;
    end
    mcnt = 0; busy_cnt = 0; post_rst = 1;
    exp_q.delete();
  endtask

  // One axis of bounce motion; "back" means moving toward coordinate 0.
  task automatic move(inout int p, input int d, inout bit back, input int s, input int lim);
    if (d == 0) return;
    if (back) begin
      if (p <= d) begin p = 0; back = 0; end
      else p = p - d;
    end else if (p + s + d >= lim) begin
      p = lim - s; back = 1;
    end else p = p + d;
  endtask

  task automatic run_pass();
    exp_t e;
    int   px, py, ps;
    for (int i = 0; i < N; i++)
      if (mact[i]) begin
        move(mx[i], mdx[i], ml[i], ms[i], SW);
        move(my[i], mdy[i], mu[i], ms[i], SH);
      end
    px = int'(player_x); py = int'(player_y); ps = int'(player_size);
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (mact[i] && !e.hit && mx[i] < px + ps && px < mx[i] + ms[i] && my[i] < py + ps && py < my[i] + ms[i]) begin
        e.hit = 1'b1;
        e.hid = 2'(i);
      end
      e.ex[i*XW +: XW] = XW'(mx[i]);
      e.ey[i*YW +: YW] = YW'(my[i]);
      e.es[i*3 +: 3]   = 3'(ms[i]);
      e.act[i]         = mact[i];
    end
    e.edge_n = edges + 2*N;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    bit idle, ready_m, tick;
    int s;
    if (reset) begin model_reset(); return; end
    idle     = (busy_cnt == 0);
    ready_m  = idle && !post_rst;
    post_rst = 0;
    if (ready_m && kill_valid) mact[kill_id] = 0;
    if (ready_m && spawn_valid) begin
      s = (spawn_size == 0) ? 1 : int'(spawn_size);
      ms[spawn_id]   = s;
      mx[spawn_id]   = (int'(spawn_x) + s > SW) ? SW - s : int'(spawn_x);
      my[spawn_id]   = (int'(spawn_y) + s > SH) ? SH - s : int'(spawn_y);
      mdx[spawn_id]  = int'(spawn_dx);
      mdy[spawn_id]  = int'(spawn_dy);
      ml[spawn_id]   = spawn_left;
      mu[spawn_id]   = spawn_up;
      mact[spawn_id] = 1;
    end
    if (busy_cnt > 0) busy_cnt--;
    tick = 0;
    if (play) begin
      if (mcnt == RD) begin tick = 1; mcnt = 0; end
      else mcnt++;
    end
    if (tick && idle) begin
      run_pass();
      busy_cnt = PASS;
    end
  endtask

  task automatic applyStimulus(input bit sv, input int sid, input int sx, input int sy, input int sdx,
                               input int sdy, input bit sl, input bit su, input int ssz,
                               input bit kv, input int kid);
    spawn_valid = sv;  spawn_id = 2'(sid); spawn_x = XW'(sx); spawn_y = YW'(sy);
    spawn_dx = 3'(sdx); spawn_dy = 3'(sdy); spawn_left = sl; spawn_up = su;
    spawn_size = 3'(ssz); kill_valid = kv; kill_id = 2'(kid);
    @(posedge clk);
    edges++;
    model_edge();
    @(negedge clk);
    spawn_valid = 0;
    kill_valid  = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (busy_cnt != 0 || post_rst); i++) idle_cycles(1);
  endtask

  task automatic spawn(input int id, input int x, input int y, input int dx, input int dy,
                       input bit l, input bit u, input int s);
    wait_idle();
    applyStimulus(1, id, x, y, dx, dy, l, u, s, 0, 0);
  endtask

  task automatic kill(input int id);
    wait_idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, id);
  endtask

  task automatic wait_frames(input int n);
    int target = frames + n;
    for (int i = 0; i < 100*n && frames < target; i++) idle_cycles(1);
    if (frames < target) begin
      vectors++; miscompares++;
      $display("[TB] FAIL frame_timeout: got %0d frames expected %0d", frames, target);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_tick === 1'b1) begin
      frames++;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_frame: got frame_tick 1 expected 0");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("frame_edge", 64'(edges), 64'(mon_e.edge_n));
        checkOutput("enemy_x", 64'(enemy_x), 64'(mon_e.ex));
        checkOutput("enemy_y", 64'(enemy_y), 64'(mon_e.ey));
        checkOutput("enemy_size", 64'(enemy_size), 64'(mon_e.es));
        checkOutput("active", 64'(active), 64'(mon_e.act));
        checkOutput("hit", 64'(hit), 64'(mon_e.hit));
        if (mon_e.hit) checkOutput("hit_id", 64'(hit_id), 64'(mon_e.hid));
      end
    end
  end

  initial begin
    int low, f0;
    reset = 1; play = 0;
    player_x = 0; player_y = 0; player_size = 0;
    model_reset();
    idle_cycles(2);
    checkOutput("rst_active", 64'(active), 0);
    checkOutput("rst_enemy_x", 64'(enemy_x), 0);
    checkOutput("rst_hit", 64'(hit), 0);
    checkOutput("rst_hit_id", 64'(hit_id), 0);
    checkOutput("rst_frame_tick", 64'(frame_tick), 0);
    checkOutput("rst_spawn_ready", 64'(spawn_ready), 0);
    reset = 0;
    play  = 1;

    // Basic motion over three frames.
    spawn(0, 10, 20, 2, 1, 0, 0, 4);
    wait_frames(3);
    checkOutput("basic_x", 64'(enemy_x[0 +: XW]), 16);
    checkOutput("basic_y", 64'(enemy_y[0 +: YW]), 23);
    checkOutput("basic_active", 64'(active), 64'b0001);

    // Left wall bounce.
    spawn(0, 3, 20, 2, 0, 1, 0, 4);
    wait_frames(1); checkOutput("left_x1", 64'(enemy_x[0 +: XW]), 1);
    wait_frames(1); checkOutput("left_x2", 64'(enemy_x[0 +: XW]), 0);
    wait_frames(1); checkOutput("left_x3", 64'(enemy_x[0 +: XW]), 2);

    // Right and bottom wall bounce.
    spawn(0, 150, 113, 3, 3, 0, 0, 4);
    wait_frames(1);
    checkOutput("right_x1", 64'(enemy_x[0 +: XW]), 153);
    checkOutput("bottom_y1", 64'(enemy_y[0 +: YW]), 116);
    wait_frames(1);
    checkOutput("right_x2", 64'(enemy_x[0 +: XW]), 156);
    checkOutput("bottom_y2", 64'(enemy_y[0 +: YW]), 113);
    wait_frames(1);
    checkOutput("right_x3", 64'(enemy_x[0 +: XW]), 153);

    // Collision priority and clearing.
    kill(0);
    wait_idle();
    player_x = 50; player_y = 50; player_size = 4;
    spawn(1, 52, 52, 0, 0, 0, 0, 2);
    wait_frames(1);
    checkOutput("coll_hit1", 64'(hit), 1);
    checkOutput("coll_id1", 64'(hit_id), 1);
    spawn(3, 51, 51, 0, 0, 0, 0, 2);
    wait_frames(1);
    checkOutput("coll_id_low", 64'(hit_id), 1);
    kill(1);
    wait_frames(1);
    checkOutput("coll_id3", 64'(hit_id), 3);
    kill(3);
    wait_frames(1);
    checkOutput("coll_clear", 64'(hit), 0);

    // Handshake: ready low for a whole pass, held spawn lands in the first idle cycle.
    wait_idle();
    for (int i = 0; i < 40 && spawn_ready !== 1'b0; i++) idle_cycles(1);
    low = 0;
    for (int i = 0; i < 40 && spawn_ready === 1'b0; i++) begin
      low++;
      applyStimulus(1, 2, 30, 30, 1, 1, 0, 0, 3, 0, 0);
    end
    checkOutput("ready_low_cycles", 64'(low), 64'(PASS));
    checkOutput("held_not_loaded", 64'(active[2]), 0);
    applyStimulus(1, 2, 30, 30, 1, 1, 0, 0, 3, 0, 0);
    checkOutput("held_loaded", 64'(active[2]), 1);
    wait_idle();
    applyStimulus(1, 2, 40, 40, 1, 1, 0, 0, 3, 1, 2);
    checkOutput("spawn_beats_kill", 64'(active[2]), 1);
    spawn(2, 158, 40, 0, 0, 0, 0, 4);
    checkOutput("spawn_clamp_x", 64'(enemy_x[2*XW +: XW]), 156);

    // Reset in the middle of an update pass, with a live hit.
    spawn(1, 52, 52, 0, 0, 0, 0, 2);
    wait_frames(1);
    checkOutput("pre_rst_hit", 64'(hit), 1);
    wait_idle();
    for (int i = 0; i < 40 && spawn_ready !== 1'b0; i++) idle_cycles(1);
    reset = 1;
    #1;
    checkOutput("midrst_active", 64'(active), 0);
    checkOutput("midrst_enemy_x", 64'(enemy_x), 0);
    checkOutput("midrst_enemy_y", 64'(enemy_y), 0);
    checkOutput("midrst_hit", 64'(hit), 0);
    checkOutput("midrst_frame_tick", 64'(frame_tick), 0);
    checkOutput("midrst_spawn_ready", 64'(spawn_ready), 0);
    @(negedge clk);
    idle_cycles(2);
    reset = 0;
    play  = 0;
    f0    = frames;
    idle_cycles(60);
    checkOutput("play0_no_frames", 64'(frames), 64'(f0));

    // Randomised traffic against the reference model.
    for (int c = 0; c < 700; c++) begin
      play = ($urandom_range(9) != 0);
      if (busy_cnt == 0 && $urandom_range(15) == 0) begin
        player_x    = XW'($urandom_range(159));
        player_y    = YW'($urandom_range(119));
        player_size = 3'($urandom_range(7));
      end
      applyStimulus($urandom_range(3) == 0, $urandom_range(N-1), $urandom_range(255), $urandom_range(127),
                    $urandom_range(7), $urandom_range(7), $urandom_range(1) == 1, $urandom_range(1) == 1,
                    $urandom_range(7), $urandom_range(4) == 0, $urandom_range(N-1));
    end

    play = 0;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle_cycles(1);
    checkOutput("pending_frames", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/enemy_bank.md
Name: enemy_bank

Overview:
Parametrised multi-enemy motion engine for the 160x120 VGA game. It holds NUM_ENEMIES bouncing square enemies, advances them once per rate tick through a time-multiplexed update pass, and checks each active enemy against the player box. It sits between the game FSM (spawn/kill/play) and the renderer/lose logic (positions, active mask, hit). It replaces per-enemy instances with one shared datapath.

Parameters:
NUM_ENEMIES, 4, enemy slots; ID_W = clog2(NUM_ENEMIES), derived localparam, min 1
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
SCREEN_W, 160, playfield width in pixels
SCREEN_H, 120, playfield height in pixels
RATE_DIV, 249999, tick period minus 1 in clk cycles; must be >= 2*NUM_ENEMIES+2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play  in  1  1 = motion counter runs
spawn_valid  in  1  spawn request
spawn_ready  out  1  1 = spawn/kill accepted this cycle
spawn_id  in  ID_W  target slot
spawn_x  in  X_W  start x (top-left)
spawn_y  in  Y_W  start y (top-left)
spawn_dx  in  3  x step per tick
spawn_dy  in  3  y step per tick
spawn_left  in  1  initial x direction, 1 = left
spawn_up  in  1  initial y direction, 1 = up
spawn_size  in  3  side length in pixels, 0 treated as 1
kill_valid  in  1  deactivate kill_id
kill_id  in  ID_W  slot to deactivate
player_x  in  X_W  player top-left x
player_y  in  Y_W  player top-left y
player_size  in  3  player side length
enemy_x  out  NUM_ENEMIES*X_W  flattened x, slot i at [i*X_W +: X_W]
enemy_y  out  NUM_ENEMIES*Y_W  flattened y
enemy_size  out  NUM_ENEMIES*3  flattened sizes
active  out  NUM_ENEMIES  slot-valid mask
hit  out  1  some active enemy overlapped player in last pass
hit_id  out  ID_W  lowest overlapping slot index
frame_tick  out  1  one-cycle pulse, pass complete

Behaviour:
- Reset (async, immediate): all position/size/direction regs 0, active 0, hit 0, hit_id 0, frame_tick 0, counter 0, FSM IDLE, spawn_ready 0 while reset is high.
- Counter: while play=1 counts 0..RATE_DIV; at RATE_DIV asserts internal tick and wraps to 0. play=0 holds the counter. A pass already in progress always completes. A tick outside IDLE is dropped (prevented by the RATE_DIV constraint).
- FSM: IDLE -> (tick) UPDATE, index 0..N-1, one slot/cycle -> COLLIDE, index 0..N-1, one slot/cycle -> DONE (frame_tick=1, hit/hit_id registered) -> IDLE. Tick in cycle T gives frame_tick in cycle T+2N+1.
- spawn_ready = (state==IDLE). Spawn transfers on valid&&ready: the slot is overwritten even if active; x clamped to SCREEN_W-size and y to SCREEN_H-size if it overflows; active bit set.
- kill_valid is honoured only when spawn_ready=1. It clears active[kill_id]. A spawn and kill on the same id in the same cycle: spawn wins.
- UPDATE, inactive slot: no change.
- UPDATE, x axis (same rules for y with dy/up/SCREEN_H). Use X_W+1-bit intermediates; no wrap-around.
  - d=0: x and direction unchanged.
  - Left: if x <= dx, x=0 and direction becomes right; else x = x-dx.
  - Right: if x+size+dx >= SCREEN_W, x = SCREEN_W-size and direction becomes left; else x = x+dx.
- COLLIDE: overlap is strict AABB: ex < px+ps AND px < ex+es AND the same on y. Only active slots count.
  - Accumulate any-hit and the lowest index.
  - Commit to hit/hit_id in DONE; hold until the next DONE.
- Outputs are driven straight from registers; no combinational path from inputs to outputs.

Test Plan:
- N=4, RATE_DIV=15. Reset, spawn id0 (10,20) dx=2 dy=1 right/down size 4, play=1 -> after 3 frame_ticks x=16, y=23, active=0001.
- Left wall: id0 x=3 dx=2 left -> frames give x=1, then x=0 with direction right, then x=2.
- Right wall: size 4, x=150 dx=3 right -> x=153, then x=156 with direction left, then x=153. Bottom wall: y=113 dy=3 down -> y=116 with direction up.
- Collision: player (50,50) size 4, id1 at (52,52) size 2 d=0 -> at frame_tick hit=1, hit_id=1. Add id3 overlapping -> hit_id stays 1. Kill id1 -> hit_id=3. Kill id3 -> hit=0 at the next frame_tick.
- Handshake: hold spawn_valid from tick cycle -> spawn_ready=0 for 2N+1 cycles, load in first IDLE cycle. Spawn+kill on id2 in one cycle -> active[2]=1. Spawn x=158 size 4 -> x=156.
- Assert reset mid-UPDATE -> outputs zero in the same cycle, no frame_tick. Deassert, play=0 -> counter frozen, no ticks.
